// File: rtl/pe_kl_stream_cell.sv
`timescale 1ns / 1ps
// pe_kl_stream_cell
// Multi-channel streaming processing element for the PE array.
// A key-lock block captures a row/column ID from the first lock word after reset or flush.
// A matching key word then enables the calculation block.
// Accepted beats pass through a DELAY_CYCLES-deep pipeline that stalls globally on
// backpressure.
// In accumulate mode, groups of ACC_LEN beats are summed per channel, saturated, and emitted
// as one beat.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset (clears everything, incl. data)
//   flush             synchronous; clears config, accumulators and in-flight valids
//   kl_valid_in       config word strobe; kl_type 0 = lock, 1 = key
//   kl_row, kl_col    ID carried by the config word; kl_mode = mode of a lock word
//   in_valid/in_ready/in_data     input stream (channel c at [c*PE_WIDTH +: PE_WIDTH])
//   out_valid/out_ready/out_data  output stream, same packing
//   pe_enabled        last key matched the programmed ID
//   pe_locked         ID programmed since last flush/rst
module pe_kl_stream_cell #(
  parameter int unsigned NUM_CH        = 2,
  parameter int unsigned PE_WIDTH      = 16,
  parameter int unsigned DELAY_CYCLES  = 10,
  parameter int unsigned ACC_LEN       = 4,
  parameter int unsigned ROW_BUS_WIDTH = 2,
  parameter int unsigned COL_BUS_WIDTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       kl_valid_in,
  input  logic                       kl_type,
  input  logic [ROW_BUS_WIDTH-1:0]   kl_row,
  input  logic [COL_BUS_WIDTH-1:0]   kl_col,
  input  logic                       kl_mode,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [NUM_CH*PE_WIDTH-1:0] in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [NUM_CH*PE_WIDTH-1:0] out_data,
  output logic                       pe_enabled,
  output logic                       pe_locked
);

  localparam int unsigned DW  = NUM_CH * PE_WIDTH;
  localparam int unsigned CW  = $clog2(ACC_LEN);
  localparam int unsigned AW  = PE_WIDTH + CW;
  localparam int unsigned IDW = ROW_BUS_WIDTH + COL_BUS_WIDTH;

  logic                    locked_q, locked_d;
  logic                    enabled_q, enabled_d;
  logic                    mode_q, mode_d;
  logic [IDW-1:0]          id_q, id_d;
  logic [DELAY_CYCLES-1:0] vld_q, vld_d;
  logic [DW-1:0]           data_q [DELAY_CYCLES];
  logic [DW-1:0]           data_d [DELAY_CYCLES];
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [AW-1:0]           acc_q [NUM_CH];
  logic [AW-1:0]           acc_d [NUM_CH];

  logic          adv;
  logic          accept;
  logic          last_beat;
  logic          stage0_vld;
  logic [DW-1:0] stage0_data;
  logic [AW-1:0] sum [NUM_CH];

  assign out_valid  = vld_q[DELAY_CYCLES-1];
  assign out_data   = data_q[DELAY_CYCLES-1];
  assign pe_enabled = enabled_q;
  assign pe_locked  = locked_q;

  // Global stall: the whole pipeline moves only when the output slot can change.
  assign adv      = !vld_q[DELAY_CYCLES-1] | out_ready;
  assign in_ready = enabled_q & adv;
  assign accept   = in_valid & in_ready;

  always_comb begin
    locked_d    = locked_q;
    enabled_d   = enabled_q;
    mode_d      = mode_q;
    id_d        = id_q;
    vld_d       = vld_q;
    data_d      = data_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    stage0_vld  = 1'b0;
    stage0_data = in_data;
    last_beat   = (cnt_q == CW'(ACC_LEN - 1));

    for (int unsigned c = 0; c < NUM_CH; c++) begin
      sum[c] = acc_q[c] + AW'(in_data[c*PE_WIDTH +: PE_WIDTH]);
    end

    // Key-lock: the first lock word wins until flush/rst; every key word re-evaluates enable.
    if (kl_valid_in) begin
      if (!kl_type) begin
        if (!locked_q) begin
          id_d     = {kl_row, kl_col};
          mode_d   = kl_mode;
          locked_d = 1'b1;
        end
      end else begin
        enabled_d = locked_q & ({kl_row, kl_col} == id_q);
      end
    end

    if (accept) begin
      if (!mode_q) begin
        stage0_vld = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
        for (int unsigned c = 0; c < NUM_CH; c++) begin
          acc_d[c] = sum[c];
        end
        if (last_beat) begin
          stage0_vld = 1'b1;
          cnt_d      = '0;
          for (int unsigned c = 0; c < NUM_CH; c++) begin
            acc_d[c] = '0;
            stage0_data[c*PE_WIDTH +: PE_WIDTH] =
                (|sum[c][AW-1:PE_WIDTH]) ? {PE_WIDTH{1'b1}} : sum[c][PE_WIDTH-1:0];
          end
        end
      end
    end

    if (adv) begin
      vld_d[0]  = stage0_vld;
      data_d[0] = stage0_data;
      for (int unsigned i = 1; i < DELAY_CYCLES; i++) begin
        vld_d[i]  = vld_q[i-1];
        data_d[i] = data_q[i-1];
      end
    end

    // Flush drops config, partial sums and in-flight valids; data registers are don't-care.
    if (flush) begin
      locked_d  = 1'b0;
      enabled_d = 1'b0;
      mode_d    = 1'b0;
      id_d      = '0;
      vld_d     = '0;
      cnt_d     = '0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        acc_d[c] = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      locked_q  <= 1'b0;
      enabled_q <= 1'b0;
      mode_q    <= 1'b0;
      id_q      <= '0;
      vld_q     <= '0;
      cnt_q     <= '0;
      for (int unsigned i = 0; i < DELAY_CYCLES; i++) begin
        data_q[i] <= '0;
      end
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        acc_q[c] <= '0;
      end
    end else begin
      locked_q  <= locked_d;
      enabled_q <= enabled_d;
      mode_q    <= mode_d;
      id_q      <= id_d;
      vld_q     <= vld_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      acc_q     <= acc_d;
    end
  end

endmodule

// File: tb/tb_pe_kl_stream_cell.sv
`timescale 1ns / 1ps
// Scoreboard bench for pe_kl_stream_cell: a recorder models key-lock state and accumulation
// arithmetic and queues expected output beats; a monitor pops and compares on each output
// handshake, including data, latency (stall-adjusted) and hold stability.
module tb_pe_kl_stream_cell;
  localparam int unsigned NCH = 2;
  localparam int unsigned W   = 16;
  localparam int unsigned D   = 10;
  localparam int unsigned AL  = 4;
  localparam int unsigned RW  = 2;
  localparam int unsigned CWB = 2;
  localparam int unsigned DW  = NCH * W;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           flush = 1'b0;
  logic           kl_valid_in = 1'b0;
  logic           kl_type = 1'b0;
  logic [RW-1:0]  kl_row = '0;
  logic [CWB-1:0] kl_col = '0;
  logic           kl_mode = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [DW-1:0]  in_data = '0;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [DW-1:0]  out_data;
  logic           pe_enabled;
  logic           pe_locked;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rdy_mode = 0;  // 0: always ready, 1: random, 2: never ready

  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
    int            st;
  } exp_t;
  exp_t exp_q[$];

  pe_kl_stream_cell #(
    .NUM_CH(NCH), .PE_WIDTH(W), .DELAY_CYCLES(D), .ACC_LEN(AL),
    .ROW_BUS_WIDTH(RW), .COL_BUS_WIDTH(CWB)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .kl_valid_in(kl_valid_in), .kl_type(kl_type), .kl_row(kl_row), .kl_col(kl_col),
    .kl_mode(kl_mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .pe_enabled(pe_enabled), .pe_locked(pe_locked)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Reference model state
  bit           locked_m, en_m, mode_m;
  logic [3:0]   id_m;
  longint       sum_m [NCH];
  int           cnt_m;
  int           stalls_in = 0;

  function automatic void model_clear();
    locked_m = 0; en_m = 0; mode_m = 0; id_m = '0; cnt_m = 0;
    for (int c = 0; c < NCH; c++) sum_m[c] = 0;
  endfunction

  // Recorder: checks control outputs against the model and pushes expected beats on accept.
  initial begin
    exp_t   e;
    longint v;
    logic [3:0] kid;
    forever begin
      @(negedge clk);
      if (rst) begin
        model_clear();
      end else begin
        chk("pe_enabled", pe_enabled, en_m);
        chk("pe_locked", pe_locked, locked_m);
        chk("in_ready", in_ready, en_m && (!out_valid || out_ready));
        if (flush) begin
          model_clear();
        end else begin
          if (in_valid && in_ready) begin
            if (!mode_m) begin
              e.data = in_data; e.cyc = cyc; e.st = stalls_in;
              exp_q.push_back(e);
            end else begin
              for (int c = 0; c < NCH; c++) sum_m[c] += longint'(in_data[c*W +: W]);
              cnt_m++;
              if (cnt_m == AL) begin
                for (int c = 0; c < NCH; c++) begin
                  v = (sum_m[c] > 65535) ? 65535 : sum_m[c];
                  e.data[c*W +: W] = v[W-1:0];
                  sum_m[c] = 0;
                end
                e.cyc = cyc; e.st = stalls_in;
                exp_q.push_back(e);
                cnt_m = 0;
              end
            end
          end
          if (kl_valid_in) begin
            kid = {kl_row, kl_col};
            if (!kl_type) begin
              if (!locked_m) begin
                id_m = kid; mode_m = kl_mode; locked_m = 1;
              end
            end else begin
              en_m = locked_m && (kid == id_m);
            end
          end
        end
      end
      if (out_valid && !out_ready) stalls_in++;
    end
  end

  // Monitor: pops and compares on each output handshake.
  initial begin
    exp_t          e;
    bit            prev_stall;
    logic [DW-1:0] prev_data;
    int            first_cyc, first_st, stalls_out;
    prev_stall = 0; prev_data = '0; first_cyc = 0; first_st = 0; stalls_out = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        prev_stall = 0;
      end else begin
        if (out_valid) begin
          if (prev_stall) chk("out_data_stable", out_data, prev_data);
          else begin
            first_cyc = cyc;
            first_st  = stalls_out;
          end
          if (out_ready) begin
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_output at cycle %0d: got %0h, expected no beat",
                       cyc, out_data);
            end else begin
              e = exp_q.pop_front();
              chk("out_data", out_data, e.data);
              chk("latency", 64'(first_cyc - e.cyc), 64'(D + (first_st - e.st)));
            end
          end
        end
        prev_stall = out_valid && !out_ready && !flush;
        prev_data  = out_data;
        if (flush) exp_q.delete();
      end
      if (out_valid && !out_ready) stalls_out++;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom % 4) != 0;
        default: out_ready = 1'b0;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic kl(input bit typ, input int r, input int c, input bit m);
    kl_valid_in = 1'b1; kl_type = typ; kl_row = r[RW-1:0]; kl_col = c[CWB-1:0]; kl_mode = m;
    tick();
    kl_valid_in = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic send(input logic [DW-1:0] d);
    bit hs;
    int n;
    hs = 0; n = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!hs && n < 100) begin
      @(negedge clk);
      hs = in_ready;
      tick();
      n++;
    end
    if (!hs) begin
      checks++;
      errors++;
      $display("FAIL send_timeout at cycle %0d: got no in_ready, expected acceptance", cyc);
    end
    in_valid = 1'b0;
  endtask

  function automatic logic [DW-1:0] pack2(input int c0, input int c1);
    logic [DW-1:0] d;
    d[W-1:0]    = c0[W-1:0];
    d[2*W-1:W]  = c1[W-1:0];
    return d;
  endfunction

  initial begin
    int n;
    int v;
    #200000;
    $display("FAIL watchdog at cycle %0d: got no finish, expected completion", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int v;
    // Reset
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_locked", pe_locked, 0);
    chk("rst_enabled", pe_enabled, 0);
    tick();

    // Pass mode, lock/key (1,2), five beats
    kl(0, 1, 2, 0);
    kl(1, 1, 2, 0);
    chk("key_match_en", pe_enabled, 1);
    for (int i = 0; i < 5; i++) send(pack2(1 + i, 'h100 + i));
    repeat (D + 3) tick();

    // Mismatching key, ignored relock
    kl(1, 2, 1, 0);
    chk("key_mismatch_en", pe_enabled, 0);
    in_valid = 1'b1; in_data = pack2(7, 7);
    repeat (5) tick();
    in_valid = 1'b0;
    kl(0, 3, 3, 0);
    kl(1, 3, 3, 0);
    chk("relock_ignored_en", pe_enabled, 0);
    chk("relock_still_locked", pe_locked, 1);
    kl(1, 1, 2, 0);
    chk("rekey_en", pe_enabled, 1);

    // Accumulate mode
    do_flush();
    chk("flush_locked", pe_locked, 0);
    kl(0, 0, 1, 1);
    kl(1, 0, 1, 1);
    send(pack2(10, 1)); send(pack2(20, 2)); send(pack2(30, 3)); send(pack2(40, 4));
    for (int i = 0; i < 4; i++) send(pack2('hFFFF, 'hFFFF));
    repeat (D + 3) tick();

    // Backpressure: hold out_ready low for 5 cycles while a beat is presented
    do_flush();
    kl(0, 2, 3, 0);
    kl(1, 2, 3, 0);
    fork
      begin
        for (int i = 0; i < 8; i++) send(pack2('h200 + i, 'h300 + i));
      end
      begin
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 60) begin
          @(negedge clk);
          n++;
        end
        chk("bp_out_seen", out_valid, 1);
        rdy_mode = 2;
        @(posedge clk);
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          chk("bp_hold_valid", out_valid, 1);
          chk("bp_in_ready", in_ready, 0);
        end
        rdy_mode = 0;
      end
    join
    repeat (D + 8) tick();

    // Flush with 6 beats in flight
    for (int i = 0; i < 6; i++) send(pack2('hA0 + i, 'hB0 + i));
    do_flush();
    chk("flush_out_valid", out_valid, 0);
    chk("flush_locked2", pe_locked, 0);
    chk("flush_enabled", pe_enabled, 0);
    repeat (D + 3) tick();
    kl(0, 1, 1, 0);
    kl(1, 1, 1, 0);
    for (int i = 0; i < 3; i++) send(pack2('hC0 + i, 'hD0 + i));
    repeat (D + 3) tick();

    // Accumulate group split by a key mismatch
    do_flush();
    kl(0, 2, 2, 1);
    kl(1, 2, 2, 1);
    send(pack2(5, 100)); send(pack2(6, 200));
    kl(1, 1, 1, 1);
    chk("acc_mismatch_en", pe_enabled, 0);
    in_valid = 1'b1; in_data = pack2(999, 999);
    repeat (3) tick();
    in_valid = 1'b0;
    kl(1, 2, 2, 1);
    send(pack2(7, 300)); send(pack2(8, 400));
    repeat (D + 3) tick();

    // Randomized phase
    rdy_mode = 1;
    for (int k = 0; k < 3000; k++) begin
      flush       = ($urandom % 300) == 0;
      kl_valid_in = ($urandom % 10) == 0;
      kl_type     = 1'($urandom);
      kl_row      = RW'($urandom % 2);
      kl_col      = CWB'($urandom % 2);
      kl_mode     = 1'($urandom);
      in_valid    = ($urandom % 4) != 0;
      for (int c = 0; c < NCH; c++) begin
        v = ($urandom % 2) ? int'($urandom_range(0, 4095)) : int'($urandom_range(0, 65535));
        in_data[c*W +: W] = v[W-1:0];
      end
      tick();
    end
    flush = 1'b0; kl_valid_in = 1'b0; in_valid = 1'b0; rdy_mode = 0;
    repeat (D + 5) tick();
    chk("queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
